// File: rtl/genius_pkg.sv
// Shared definitions for the Genius sequence player: FSM state codes, speed codes
// and the colour-code to one-hot LED mapping.
package genius_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] speed_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    localparam logic [1:0] SPD_025 = 2'd0;
    localparam logic [1:0] SPD_05  = 2'd1;
    localparam logic [1:0] SPD_1   = 2'd2;
    localparam logic [1:0] SPD_2   = 2'd3;

    function automatic logic [3:0] colour_led(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/rate_tick_sync.sv
// Brings the four slow rate square waves into the CLOCK_50 domain and turns rising
// edges of the selected one into single-cycle ticks.
module rate_tick_sync
    import genius_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       C025Hz,
    input  logic       C05Hz,
    input  logic       C1Hz,
    input  logic       C2Hz,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [3:0] rate;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] prev_p2;

    assign rate[SPD_025] = C025Hz;
    assign rate[SPD_05]  = C05Hz;
    assign rate[SPD_1]   = C1Hz;
    assign rate[SPD_2]   = C2Hz;

    // p0/p1: two-flop synchroniser; p2: previous synchronised level for edge detection
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
        end else begin
            sync_p0 <= rate;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign tick = sync_p1[speed] & ~prev_p2[speed];

endmodule

// File: rtl/genius_seq_player.sv
// Plays the stored Genius colour sequence on four LEDs, one colour per tick period of
// the selected slow rate, with an equally long dark gap after each colour.
module genius_seq_player
    import genius_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    localparam int IW      = $clog2(MAX_LEN)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          C025Hz,
    input  logic          C05Hz,
    input  logic          C1Hz,
    input  logic          C2Hz,
    input  logic [1:0]    speed_sel,
    input  logic          start,
    input  logic [IW:0]   seq_len,
    output logic          rd_en,
    output logic [IW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [3:0]    led,
    output logic          busy,
    output logic          done
);

    localparam logic [IW:0] LEN_CAP = (IW+1)'(MAX_LEN);

    logic [2:0]    state;
    logic [1:0]    speed_r;
    logic [IW:0]   len_r;
    logic [IW-1:0] idx;
    logic          tick;
    logic          last;

    rate_tick_sync u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .C025Hz   (C025Hz),
        .C05Hz    (C05Hz),
        .C1Hz     (C1Hz),
        .C2Hz     (C2Hz),
        .speed    (speed_r),
        .tick     (tick)
    );

    assign rd_en = (state == ST_FETCH);
    assign last  = ({1'b0, idx} == len_r - 1'b1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            led     <= '0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    if (seq_len == '0) begin
                        state <= ST_FIN;
                    end else begin
                        busy    <= 1'b1;
                        rd_addr <= '0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    led   <= colour_led(rd_data);
                    state <= ST_SHOW;
                end
                // Ticks during FETCH/WAIT are dropped, so a colour never shows longer than a period
                ST_SHOW: if (tick) begin
                    led   <= '0;
                    state <= ST_GAP;
                end
                ST_GAP: if (tick) begin
                    if (last) begin
                        state <= ST_FIN;
                    end else begin
                        rd_addr <= idx + 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (state == ST_IDLE && start) begin
            speed_r <= speed_sel;
            len_r   <= (seq_len > LEN_CAP) ? LEN_CAP : seq_len;
            idx     <= '0;
        end else if (state == ST_GAP && tick && !last) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_genius_seq_player.sv
// Scoreboard bench for genius_seq_player: expected read/LED/done events with their
// cycle spacing are queued by the stimulus and consumed by an independent monitor.
module tb_genius_seq_player;

    localparam int EV_RD   = 0;
    localparam int EV_LED  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int val;
        int dly;
    } ev_t;

    logic       CLOCK_50;
    logic       reset;
    logic       C025Hz, C05Hz, C1Hz, C2Hz;
    logic [1:0] speed_sel;
    logic       start;
    logic [5:0] seq_len;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] led;
    logic       busy;
    logic       done;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         wcyc = 0;
    int         last_cyc = 0;
    int         done_total = 0;
    logic       mon_en = 1'b0;
    logic       man_en = 1'b0;
    logic       man_val = 1'b0;
    logic [3:0] led_prev = 4'b0;
    logic [1:0] mem [0:31];
    logic [1:0] pend_d = 2'b0;
    logic       pend_v = 1'b0;

    genius_seq_player #(.MAX_LEN(32)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .C025Hz    (C025Hz),
        .C05Hz     (C05Hz),
        .C1Hz      (C1Hz),
        .C2Hz      (C2Hz),
        .speed_sel (speed_sel),
        .start     (start),
        .seq_len   (seq_len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial forever begin
        @(posedge CLOCK_50);
        cyc = cyc + 1;
    end

    // Scaled rate waves: C2Hz period 32 cycles, doubling down to C025Hz at 256 cycles
    initial begin
        C025Hz = 1'b0; C05Hz = 1'b0; C1Hz = 1'b0; C2Hz = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            wcyc   = wcyc + 1;
            C025Hz = wcyc[7];
            C05Hz  = man_en ? man_val : wcyc[6];
            C1Hz   = wcyc[5];
            C2Hz   = wcyc[4];
        end
    end

    // Memory model: data is wrong during the rd_en cycle and correct one cycle later
    initial begin
        rd_data = 2'b0;
        forever begin
            @(negedge CLOCK_50);
            if (rd_en) begin
                pend_d  = mem[rd_addr];
                rd_data = mem[rd_addr] ^ 2'b11;
                pend_v  = 1'b1;
            end else if (pend_v) begin
                rd_data = pend_d;
                pend_v  = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int dly);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.dly  = dly;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL unexpected_event: got kind %0d value %0d, expected no event (cycle %0d)",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
            if (e.dly >= 0) check("event_spacing", cyc - last_cyc, e.dly);
        end
        last_cyc = cyc;
    endtask

    initial forever begin
        @(negedge CLOCK_50);
        if (done) done_total = done_total + 1;
        if (mon_en) begin
            if (rd_en) observe(EV_RD, int'(rd_addr));
            if (led != led_prev) observe(EV_LED, int'(led));
            if (done) observe(EV_DONE, 0);
        end
        led_prev = led;
    end

    task automatic do_start(input logic [1:0] spd, input int len, input bit mark);
        @(negedge CLOCK_50);
        speed_sel = spd;
        seq_len   = len[5:0];
        start     = 1'b1;
        if (mark) last_cyc = cyc;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget, input int idle);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLOCK_50);
            n = n + 1;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (idle) @(negedge CLOCK_50);
    endtask

    task automatic wait_led_on(input string name, input int budget);
        int n = 0;
        while (led == 4'b0 && n < budget) begin
            @(negedge CLOCK_50);
            n = n + 1;
        end
        check(name, int'(led != 4'b0), 1);
    endtask

    task automatic set_c05(input logic v, input bit mark);
        @(posedge CLOCK_50);
        #1;
        man_val = v;
        if (mark) last_cyc = cyc;
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; seq_len = '0; speed_sel = 2'd0;
        for (int i = 0; i < 32; i++) mem[i] = 2'd0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        mon_en = 1'b1;

        // Play three colours at C2Hz
        mem[0] = 2'd0; mem[1] = 2'd2; mem[2] = 2'd3;
        push(EV_RD, 0, 1);   push(EV_LED, 1, 2);  push(EV_LED, 0, -1);
        push(EV_RD, 1, 32);  push(EV_LED, 4, 2);  push(EV_LED, 0, 30);
        push(EV_RD, 2, 32);  push(EV_LED, 8, 2);  push(EV_LED, 0, 30);
        push(EV_DONE, 0, 33);
        d0 = done_total;
        do_start(2'd3, 3, 1'b1);
        wait_drain("play_drain", 400, 40);
        check("play_done_count", done_total - d0, 1);

        // Empty sequence
        push(EV_DONE, 0, 2);
        d0 = done_total;
        do_start(2'd2, 0, 1'b1);
        wait_drain("empty_drain", 20, 40);
        check("empty_done_count", done_total - d0, 1);
        check("empty_led", int'(led), 0);

        // Second start while busy is ignored
        push(EV_RD, 0, 1);   push(EV_LED, 1, 2);  push(EV_LED, 0, -1);
        push(EV_RD, 1, 32);  push(EV_LED, 4, 2);  push(EV_LED, 0, 30);
        push(EV_DONE, 0, 33);
        d0 = done_total;
        do_start(2'd3, 2, 1'b1);
        wait_led_on("busy_reach_show", 100);
        check("busy_in_show", int'(busy), 1);
        do_start(2'd0, 3, 1'b0);
        wait_drain("busy_drain", 400, 40);
        check("busy_done_count", done_total - d0, 1);

        // Speed latched at start: C025Hz keeps pacing after speed_sel changes
        mem[0] = 2'd1; mem[1] = 2'd3;
        push(EV_RD, 0, 1);   push(EV_LED, 2, 2);  push(EV_LED, 0, -1);
        push(EV_RD, 1, 256); push(EV_LED, 8, 2);  push(EV_LED, 0, 254);
        push(EV_DONE, 0, 257);
        do_start(2'd0, 2, 1'b1);
        wait_led_on("latch_reach_show", 600);
        speed_sel = 2'd3;
        wait_drain("latch_drain", 1500, 40);

        // Tick latency and falling-edge immunity on a hand-driven C05Hz
        man_val = 1'b1; man_en = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        mem[0] = 2'd0;
        push(EV_RD, 0, 1); push(EV_LED, 1, 2);
        do_start(2'd1, 1, 1'b1);
        wait_drain("lat_show_drain", 20, 0);
        set_c05(1'b0, 1'b0);
        repeat (8) @(negedge CLOCK_50);
        check("fall_in_show_led", int'(led), 1);
        push(EV_LED, 0, 3);
        set_c05(1'b1, 1'b1);
        wait_drain("lat_rise_show", 20, 0);
        push(EV_DONE, 0, 4);
        set_c05(1'b0, 1'b0);
        repeat (8) @(negedge CLOCK_50);
        check("fall_in_gap_busy", int'(busy), 1);
        set_c05(1'b1, 1'b1);
        wait_drain("lat_rise_gap", 20, 20);
        man_en = 1'b0;

        // Asynchronous reset in the middle of SHOW
        mon_en = 1'b0;
        do_start(2'd3, 3, 1'b0);
        wait_led_on("rst_reach_show", 200);
        @(posedge CLOCK_50);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_reset_led", int'(led), 0);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        d0 = done_total;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        check("post_reset_no_done", done_total - d0, 0);
        check("post_reset_led", int'(led), 0);
        check("post_reset_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
